// File: rtl/serial_sub8_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_sub8_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BorrowIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             BorrowOut;

  modport master (output start, A, B, BorrowIn, input busy, done, Diff, BorrowOut);
  modport slave  (input start, A, B, BorrowIn, output busy, done, Diff, BorrowOut);
endinterface

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: Diff = A - B - BorrowIn, LSB first, one bit per clock.
// Results land in Diff/BorrowOut only on completion and hold until the next op or reset.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  serial_sub8_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res, diff_q;
  logic             br, bo_q;
  logic [CW-1:0]    cnt;
  logic             d, br_nxt;

  // one full-subtractor cell on the current LSBs
  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new start just like IDLE, so ops can run back-to-back
          if (bus.start) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            br    <= bus.BorrowIn;
            res   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res  <= {d, res[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q <= {d, res[WIDTH-1:1]};
            bo_q   <= br_nxt;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.Diff      = diff_q;
  assign bus.BorrowOut = bo_q;
endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: directed corners, mid-op disturbances and random ops.
module tb_serial_sub8;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;
  int   npush = 0;
  int   ndone = 0;
  op_t  expq[$];

  serial_sub8_if #(.WIDTH(W)) bus ();
  serial_sub8 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 9-bit arithmetic on the operands, plus the adder-form identity
  task automatic check_result(input op_t o);
    logic [W:0] sub, add;
    sub = {1'b0, o.a} - {1'b0, o.b} - {{W{1'b0}}, o.bi};
    add = {1'b0, o.a} + {1'b0, ~o.b} + {{W{1'b0}}, ~o.bi};
    chk($sformatf("diff %h-%h-%0d", o.a, o.b, o.bi), {24'd0, bus.Diff}, {24'd0, sub[W-1:0]});
    chk($sformatf("borrow %h-%h-%0d", o.a, o.b, o.bi), {31'd0, bus.BorrowOut}, {31'd0, sub[W]});
    chk("adder-form", {23'd0, ~bus.BorrowOut, bus.Diff}, {23'd0, add});
  endtask

  // Monitor: pops on done, checks busy length and that results hold between completions
  initial begin : monitor
    logic [W-1:0] hold_d;
    logic         hold_b;
    int           busy_run;
    op_t          o;
    hold_d = '0; hold_b = 1'b0; busy_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_d = '0; hold_b = 1'b0; busy_run = 0;
      end else if (bus.done) begin
        ndone++;
        chk("busy cycles before done", busy_run, W);
        chk("busy during done", {31'd0, bus.busy}, 0);
        busy_run = 0;
        if (expq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL unexpected done: got Diff=%h expected no completion", bus.Diff);
        end else begin
          o = expq.pop_front();
          check_result(o);
        end
        hold_d = bus.Diff; hold_b = bus.BorrowOut;
      end else begin
        if (bus.busy) busy_run++;
        else busy_run = 0;
        chk("Diff held", {24'd0, bus.Diff}, {24'd0, hold_d});
        chk("BorrowOut held", {31'd0, bus.BorrowOut}, {31'd0, hold_b});
      end
    end
  end

  // Issue one op once the DUT can accept; called just after a rising edge
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input int mode);
    int t;
    op_t o;
    t = 0;
    while (bus.busy && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      ncmp++; nerr++;
      $display("FAIL accept timeout: got busy=1 expected busy=0 within 50 cycles");
    end
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.BorrowIn = bi;
    o.a = a; o.b = b; o.bi = bi;
    expq.push_back(o); npush++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (mode == 1) begin
      bus.A = 8'hAA; bus.B = 8'hAA; bus.BorrowIn = 1'b0;
    end else begin
      bus.A = W'($urandom); bus.B = W'($urandom); bus.BorrowIn = 1'($urandom);
    end
    if (mode == 2) begin
      // stray start in the third busy cycle must be ignored
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.A = 8'h77; bus.B = 8'h00; bus.BorrowIn = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"}, {31'd0, bus.busy}, 0);
    chk({tag, " done"}, {31'd0, bus.done}, 0);
    chk({tag, " Diff"}, {24'd0, bus.Diff}, 0);
    chk({tag, " BorrowOut"}, {31'd0, bus.BorrowOut}, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    int t;
    op_t dropped;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.BorrowIn = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_vals("reset");
    reset = 1'b0;
    idle_cycles(2);

    do_op(8'h05, 8'h03, 1'b0, 0);
    idle_cycles(12);
    do_op(8'h00, 8'h01, 1'b0, 0);
    idle_cycles(12);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    idle_cycles(12);
    do_op(8'h10, 8'h05, 1'b1, 1);
    idle_cycles(12);
    do_op(8'h12, 8'h34, 1'b0, 2);
    // back-to-back: the next start arrives in the DONE cycle
    do_op(8'h80, 8'h7F, 1'b1, 0);
    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);
    do_op(8'hFF, 8'h00, 1'b0, 0);
    idle_cycles(12);

    // reset in the fourth SHIFT cycle aborts with no done pulse
    do_op(8'h3C, 8'h11, 1'b0, 0);
    idle_cycles(3);
    reset = 1'b1;
    dropped = expq.pop_back(); npush--;
    @(posedge clk); #1;
    check_reset_vals("mid-op reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(12);
    do_op(8'hC3, 8'h44, 1'b1, 0);
    idle_cycles(12);

    for (int i = 0; i < 2500; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 12));
    end

    t = 0;
    while (expq.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    idle_cycles(3);
    chk("pending results", expq.size(), 0);
    chk("done pulses", ndone, npush);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
- Bit-serial subtractor: computes DIFF = A - B - BorrowIn, LSB first, one bit per clock.
- Uses a start/busy/done handshake.
- Inverse-direction companion to the team's 8-bit ripple full adder (FADDER8).
- Serves as an area-lean subtract unit in the datapath; its result can be cross-checked against FADDER8 (A + ~B + ~BorrowIn).

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2; bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  request; sampled only when not busy
A  input  WIDTH  minuend; sampled on accepting edge only
B  input  WIDTH  subtrahend; sampled on accepting edge only
BorrowIn  input  1  initial borrow; sampled on accepting edge only
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result valid
Diff  output  WIDTH  difference, held until next accepted start or reset
BorrowOut  output  1  final borrow (1 = A < B + BorrowIn unsigned), held with Diff

Behaviour:
- One clock domain. Reset is synchronous and active-high; it wins over every other input.
- Reset values (next edge with reset=1):
  - state=IDLE; busy=0; done=0; Diff=0; BorrowOut=0
  - internal shift registers, borrow flop and counter = 0
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 at edge E0 accepts the operation.
    - Latch A into a_sr, B into b_sr, BorrowIn into br; cnt=0; clear result shift register.
    - Go to SHIFT; busy=1 from E0.
  - SHIFT, each edge:
    - d = a_sr[0] ^ b_sr[0] ^ br
    - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)
    - Result register shifts right with d entering at MSB; a_sr and b_sr shift right; cnt++.
    - On the edge where cnt==WIDTH-1: copy the completed result into Diff, br_next into BorrowOut.
    - Go to DONE; busy=0, done=1.
  - DONE: lasts exactly one cycle (done=1).
    - start=1 here is accepted exactly as in IDLE (back-to-back, no gap).
    - Otherwise go to IDLE; done=0.
- Latency: start accepted at E0 → Diff/BorrowOut updated and done=1 after edge E(WIDTH). That is E8 for the default: 8 busy cycles, then the done cycle.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1: ignored. Operands are not resampled and the in-flight result is unaffected.
- Diff/BorrowOut change only at completion or reset. They are never exposed partially and stay stable through IDLE indefinitely.
- Reset mid-SHIFT: abort immediately, with no done pulse. All outputs return to reset values.
- Arithmetic: modulo 2^WIDTH. Diff + B + BorrowIn == A + BorrowOut·2^WIDTH must hold for every completed operation.
- Inputs A/B/BorrowIn may change freely after the accepting edge.

Test Plan:
- Basic: A=8'h05, B=8'h03, BorrowIn=0, start pulse → busy high 8 cycles, then done=1 for 1 cycle, Diff=8'h02, BorrowOut=0.
- Underflow: A=8'h00, B=8'h01, BorrowIn=0 → Diff=8'hFF, BorrowOut=1. With A=8'hFF, B=8'hFF, BorrowIn=1 → Diff=8'hFF, BorrowOut=1.
- Borrow-in chain: A=8'h10, B=8'h05, BorrowIn=1 → Diff=8'h0A, BorrowOut=0. Change A/B to 8'hAA mid-op → result unchanged.
- Start while busy: second start at cycle 3 with A=8'h77 → ignored, exactly one done pulse, Diff from the first op. Then start held high through the DONE cycle → next op accepted with no idle cycle, done again 9 cycles later.
- Reset mid-op: reset=1 at cycle 4 of SHIFT → next edge busy=0, done=0, Diff=0, BorrowOut=0, no done pulse. A new start afterwards completes normally.
- Exhaustive: nested loops over all 256×256 A/B with BorrowIn ∈ {0,1}, compared against the model {BorrowOut,Diff} = {1'b0,A} - B - BorrowIn. Also check {~BorrowOut, Diff} against FADDER8(A, ~B, ~BorrowIn) → zero mismatches.
